// File: rtl/ahb_bram_spi_preload.sv
// Boot loader: streams an image from SPI flash (READ 0x03) into the 128-bit AHB BRAM and holds the CPU in reset until it lands.
// Define PRELOAD_CHECKSUM_EN to read and verify a trailing checksum word after the image.
module ahb_bram_spi_preload #(
  parameter int          ADDRESSWIDTH = 18,
  parameter int          IMAGE_WORDS  = 16384,
  parameter logic [23:0] FLASH_BASE   = 24'h000000,
  parameter int          SPI_DIV      = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    RESTART,
  output logic                    SPI_SCK,
  output logic                    SPI_CSn,
  output logic                    SPI_MOSI,
  input  logic                    SPI_MISO,
  output logic [ADDRESSWIDTH-1:0] HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [127:0]            HWDATA,
  input  logic                    HREADY,
  output logic                    PRELOAD_BUSY,
  output logic                    PRELOAD_DONE,
  output logic                    PRELOAD_ERR,
  output logic                    CPU_HOLD
);

  // state | meaning
  // IDLE  | first cycle out of reset, launches the flash command
  // CMD   | shifting READ opcode + 24-bit flash address on MOSI
  // RDATA | shifting in one 128-bit image word from MISO
  // ADDR  | AHB address phase (NONSEQ write), waits for HREADY
  // DATA  | AHB data phase, waits for HREADY, then next word
  // CHK   | shifting in the checksum trailer word (option only)
  // DONE  | image loaded, CSn released, waits for RESTART
  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_RDATA,
    S_ADDR,
    S_DATA,
`ifdef PRELOAD_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  localparam int                IDX_W      = ADDRESSWIDTH - 4;
  localparam int                DIV_W      = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(SPI_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(IMAGE_WORDS - 1);
  localparam logic [31:0]       CMD_WORD   = {8'h03, FLASH_BASE};
  localparam logic [1:0]        HT_IDLE    = 2'b00;
  localparam logic [1:0]        HT_NONSEQ  = 2'b10;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [6:0]       bit_cnt;
  logic [IDX_W-1:0] word_idx;
  logic [6:0]       bit_pos;

  // bit_cnt counts down from 127; flash byte n lands in bits [8n+7:8n], MSB first
  assign bit_pos = {~bit_cnt[6:3], bit_cnt[2:0]};
  assign HSIZE   = 3'b100;

`ifdef PRELOAD_CHECKSUM_EN
  logic [31:0] csum;
  logic        csum_bad;
  assign csum_bad = (HWDATA[31:0] != csum);
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= S_IDLE;
      SPI_SCK      <= 1'b0;
      SPI_CSn      <= 1'b1;
      SPI_MOSI     <= 1'b0;
      HADDR        <= '0;
      HTRANS       <= HT_IDLE;
      HWRITE       <= 1'b0;
      HWDATA       <= '0;
      PRELOAD_BUSY <= 1'b0;
      PRELOAD_DONE <= 1'b0;
      PRELOAD_ERR  <= 1'b0;
      CPU_HOLD     <= 1'b1;
      div_cnt      <= DIV_RELOAD;
      bit_cnt      <= '0;
      word_idx     <= '0;
`ifdef PRELOAD_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state        <= S_CMD;
          SPI_CSn      <= 1'b0;
          SPI_SCK      <= 1'b0;
          SPI_MOSI     <= CMD_WORD[31];
          bit_cnt      <= 7'd31;
          div_cnt      <= DIV_RELOAD;
          PRELOAD_BUSY <= 1'b1;
        end
        S_CMD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_RELOAD;
            SPI_SCK <= ~SPI_SCK;
            // MOSI only moves on the falling edge so the flash sees it stable at the rise
            if (SPI_SCK) begin
              if (bit_cnt == '0) begin
                SPI_MOSI <= 1'b0;
                bit_cnt  <= 7'd127;
                state    <= S_RDATA;
              end else begin
                SPI_MOSI <= CMD_WORD[bit_cnt[4:0] - 5'd1];
                bit_cnt  <= bit_cnt - 7'd1;
              end
            end
          end
        end
`ifdef PRELOAD_CHECKSUM_EN
        S_RDATA, S_CHK: begin
`else
        S_RDATA: begin
`endif
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_RELOAD;
            SPI_SCK <= ~SPI_SCK;
            if (!SPI_SCK) begin
              HWDATA[bit_pos] <= SPI_MISO;
            end else if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 7'd1;
            end else begin
              if (state == S_RDATA) begin
                state  <= S_ADDR;
                HTRANS <= HT_NONSEQ;
                HWRITE <= 1'b1;
                HADDR  <= {word_idx, 4'b0000};
              end
`ifdef PRELOAD_CHECKSUM_EN
              else begin
                state        <= S_DONE;
                SPI_CSn      <= 1'b1;
                PRELOAD_BUSY <= 1'b0;
                PRELOAD_DONE <= 1'b1;
                PRELOAD_ERR  <= csum_bad;
                CPU_HOLD     <= csum_bad;
              end
`endif
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            HTRANS <= HT_IDLE;
            HWRITE <= 1'b0;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            word_idx <= word_idx + IDX_W'(1);
`ifdef PRELOAD_CHECKSUM_EN
            csum <= csum + HWDATA[31:0] + HWDATA[63:32] + HWDATA[95:64] + HWDATA[127:96];
`endif
            if (word_idx == LAST_IDX) begin
`ifdef PRELOAD_CHECKSUM_EN
              state   <= S_CHK;
              bit_cnt <= 7'd127;
`else
              state        <= S_DONE;
              SPI_CSn      <= 1'b1;
              PRELOAD_BUSY <= 1'b0;
              PRELOAD_DONE <= 1'b1;
              CPU_HOLD     <= 1'b0;
`endif
            end else begin
              state   <= S_RDATA;
              bit_cnt <= 7'd127;
            end
          end
        end
        S_DONE: begin
          if (RESTART) begin
            state        <= S_CMD;
            SPI_CSn      <= 1'b0;
            SPI_SCK      <= 1'b0;
            SPI_MOSI     <= CMD_WORD[31];
            bit_cnt      <= 7'd31;
            div_cnt      <= DIV_RELOAD;
            word_idx     <= '0;
            PRELOAD_BUSY <= 1'b1;
            PRELOAD_DONE <= 1'b0;
            PRELOAD_ERR  <= 1'b0;
            CPU_HOLD     <= 1'b1;
`ifdef PRELOAD_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_bram_spi_preload.sv
// Bench for ahb_bram_spi_preload: SPI flash model, AHB scoreboard and directed load/restart/reset scenarios.
// Covers the PRELOAD_CHECKSUM_EN build when the macro is defined for both files.
module tb_ahb_bram_spi_preload;
  localparam int          AW = 18;
  localparam int          W  = 3;
  localparam int          D  = 2;
  localparam logic [23:0] FB = 24'h123456;

  logic            HCLK = 1'b0;
  logic            HRESET = 1'b1;
  logic            RESTART = 1'b0;
  logic            SPI_SCK, SPI_CSn, SPI_MOSI;
  logic            SPI_MISO = 1'b0;
  logic [AW-1:0]   HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [127:0]    HWDATA;
  logic            HREADY = 1'b1;
  logic            PRELOAD_BUSY, PRELOAD_DONE, PRELOAD_ERR, CPU_HOLD;

  ahb_bram_spi_preload #(.ADDRESSWIDTH(AW), .IMAGE_WORDS(W), .FLASH_BASE(FB), .SPI_DIV(D)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .RESTART(RESTART),
    .SPI_SCK(SPI_SCK), .SPI_CSn(SPI_CSn), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .PRELOAD_BUSY(PRELOAD_BUSY), .PRELOAD_DONE(PRELOAD_DONE), .PRELOAD_ERR(PRELOAD_ERR), .CPU_HOLD(CPU_HOLD)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- image model ----------------
  logic [7:0] salt = 8'h00;
  int         trailer_bad = 0;

  function automatic logic [7:0] image_byte(input int rel);
    return 8'(rel) + salt;
  endfunction

  function automatic logic [127:0] model_word(input int idx);
    logic [127:0] w;
    for (int n = 0; n < 16; n++) w[8*n +: 8] = image_byte(idx * 16 + n);
    return w;
  endfunction

  function automatic logic [31:0] model_sum();
    logic [31:0]  s = '0;
    logic [127:0] w;
    for (int i = 0; i < W; i++) begin
      w = model_word(i);
      for (int l = 0; l < 4; l++) s += w[32*l +: 32];
    end
    return s;
  endfunction

  function automatic logic [7:0] flash_byte(input int rel);
    logic [31:0] t;
    if (rel >= W * 16) begin
      t = model_sum() + 32'(trailer_bad);
      if (rel - W * 16 < 4) return t[8*(rel - W*16) +: 8];
      return 8'hA5;
    end
    return image_byte(rel);
  endfunction

  // ---------------- SPI flash model (mode 0, continuous READ) ----------------
  logic [31:0] f_cmd = '0;
  logic [31:0] last_cmd = '0;
  int          f_bits = 0;
  int          f_out = 0;
  int          cmd_count = 0;
  logic        f_sck_q = 1'b0;

  always @(SPI_CSn, SPI_SCK) begin
    logic [7:0] b;
    int         rel;
    if (SPI_CSn) begin
      f_bits = 0;
      f_out  = 0;
    end else if (SPI_SCK === 1'b1 && !f_sck_q) begin
      if (f_bits < 32) begin
        f_cmd = {f_cmd[30:0], SPI_MOSI};
        f_bits++;
        if (f_bits == 32) begin
          last_cmd = f_cmd;
          cmd_count++;
          chk("flash_cmd", f_cmd, {8'h03, FB});
        end
      end
    end else if (SPI_SCK === 1'b0 && f_sck_q && f_bits >= 32) begin
      rel = int'(f_cmd[23:0]) - int'(FB) + f_out / 8;
      b = flash_byte(rel);
      SPI_MISO = b[7 - (f_out % 8)];
      f_out++;
    end
    f_sck_q = (SPI_SCK === 1'b1);
  end

  // ---------------- AHB / SPI monitor ----------------
  int           cyc = 0, writes = 0, stall_cyc = 0, exp_idx = 0, sck_len = 0;
  int           load_gen = 0, load_seen = 0;
  bit           in_data = 1'b0;
  logic         p_sck = 1'b0;
  logic [1:0]   p_htrans = '0;
  logic         p_hwrite = 1'b0;
  logic [AW-1:0] p_haddr = '0;
  logic [2:0]   p_hsize = 3'b100;
  logic [127:0] p_hwdata = '0;
  logic [127:0] got_word [W];

  always @(posedge HCLK) begin
    #1;
    cyc++;
    if (load_gen != load_seen) begin
      load_seen = load_gen;
      exp_idx   = 0;
      in_data   = 1'b0;
    end
    if (HRESET) begin
      in_data = 1'b0;
      sck_len = 0;
    end else begin
      if (in_data) begin
        chk("data_phase_htrans", p_htrans, 2'b00);
        chk("data_phase_sck", p_sck, 1'b0);
        if (HREADY) begin
          chk("hwdata", p_hwdata, model_word(exp_idx));
          if (exp_idx < W) got_word[exp_idx] = p_hwdata;
          exp_idx++;
          writes++;
          in_data = 1'b0;
        end else begin
          stall_cyc++;
          chk("hwdata_hold", HWDATA, p_hwdata);
        end
      end else if (p_htrans == 2'b10) begin
        chk("addr_in_image", exp_idx < W, 1'b1);
        chk("haddr", p_haddr, exp_idx * 16);
        chk("hwrite", p_hwrite, 1'b1);
        chk("hsize", p_hsize, 3'b100);
        chk("addr_phase_sck", p_sck, 1'b0);
        if (HREADY) in_data = 1'b1;
        else begin
          stall_cyc++;
          chk("addr_hold", {HTRANS, HADDR}, {p_htrans, p_haddr});
        end
      end else begin
        chk("htrans_idle", p_htrans, 2'b00);
      end
      if (SPI_SCK != p_sck) begin
        if (p_sck) chk("sck_high_len", sck_len, D);
        chk("sck_needs_cs", SPI_CSn, 1'b0);
        sck_len = 1;
      end else begin
        sck_len++;
      end
      chk("hold_while_busy", PRELOAD_BUSY && !CPU_HOLD, 1'b0);
    end
    p_sck = SPI_SCK; p_htrans = HTRANS; p_hwrite = HWRITE;
    p_haddr = HADDR; p_hsize = HSIZE; p_hwdata = HWDATA;
  end

  // ---------------- HREADY stall driver ----------------
  bit stall_en = 1'b0;
  int stall_cnt = 0;

  always @(negedge HCLK) begin
    if (stall_en && (HTRANS == 2'b10 || in_data) && stall_cnt < 3) begin
      HREADY = 1'b0;
      stall_cnt++;
    end else begin
      HREADY = 1'b1;
      stall_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_load(input bit poke, input string tag, input logic exp_err);
    int c0, w0, s0, n, base;
    n = 0;
    while (!PRELOAD_BUSY && n < 10) begin @(negedge HCLK); n++; end
    chk({tag, "_busy_start"}, PRELOAD_BUSY, 1'b1);
    chk({tag, "_cs_low"}, SPI_CSn, 1'b0);
    c0 = cyc; w0 = writes; s0 = stall_cyc;
    n = 0;
    while (!PRELOAD_DONE && n < 20000) begin
      @(negedge HCLK);
      n++;
      RESTART = (poke && n == 300);
    end
    RESTART = 1'b0;
    chk({tag, "_done"}, PRELOAD_DONE, 1'b1);
    base = 64 * D + W * (256 * D + 2);
`ifdef PRELOAD_CHECKSUM_EN
    base += 256 * D;
`endif
    chk({tag, "_cycles"}, cyc - c0, base + (stall_cyc - s0));
    chk({tag, "_writes"}, writes - w0, W);
    chk({tag, "_busy_end"}, PRELOAD_BUSY, 1'b0);
    chk({tag, "_err"}, PRELOAD_ERR, exp_err);
    chk({tag, "_hold"}, CPU_HOLD, exp_err);
    chk({tag, "_cs_high"}, SPI_CSn, 1'b1);
  endtask

  task automatic restart(input logic [7:0] s, input int bad);
    salt = s;
    trailer_bad = bad;
    RESTART = 1'b1;
    load_gen++;
    @(negedge HCLK);
    RESTART = 1'b0;
    chk("rs_done", PRELOAD_DONE, 1'b0);
    chk("rs_busy", PRELOAD_BUSY, 1'b1);
    chk("rs_hold", CPU_HOLD, 1'b1);
    chk("rs_err", PRELOAD_ERR, 1'b0);
    chk("rs_cs", SPI_CSn, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, w0;
    repeat (3) @(negedge HCLK);
    chk("reset_spi", {SPI_CSn, SPI_SCK, SPI_MOSI}, 3'b100);
    chk("reset_ahb", {HTRANS, HWRITE, HADDR, HSIZE}, {2'b00, 1'b0, {AW{1'b0}}, 3'b100});
    chk("reset_hwdata", HWDATA, 128'h0);
    chk("reset_status", {PRELOAD_BUSY, PRELOAD_DONE, PRELOAD_ERR, CPU_HOLD}, 4'b0001);

    // plain load from reset release
    HRESET = 1'b0;
    load_gen++;
    run_load(1'b0, "load1", 1'b0);
    chk("load1_mosi_stream", last_cmd, 32'h03123456);
    chk("load1_word0", got_word[0], 128'h0F0E0D0C0B0A09080706050403020100);
    chk("load1_word1", got_word[1], 128'h1F1E1D1C1B1A19181716151413121110);

    // reload with HREADY stalls of 3 cycles in both phases
    restart(8'h40, 0);
    stall_en = 1'b1;
    run_load(1'b0, "stall", 1'b0);
    stall_en = 1'b0;
    chk("stall_word0", got_word[0], 128'h4F4E4D4C4B4A49484746454443424140);

    // RESTART while busy must be ignored
    restart(8'h80, 0);
    run_load(1'b1, "poke", 1'b0);
    chk("poke_word2", got_word[2], 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

    // HRESET during word 1 read, then a full reload
    restart(8'h11, 0);
    w0 = writes;
    c = 0;
    while (writes == w0 && c < 3000) begin @(negedge HCLK); c++; end
    chk("midrst_first_write", writes - w0, 1);
    repeat (30) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("midrst_spi", {SPI_CSn, SPI_SCK}, 2'b10);
    chk("midrst_ahb", {HTRANS, HWRITE}, 3'b000);
    chk("midrst_status", {PRELOAD_BUSY, PRELOAD_DONE, CPU_HOLD}, 3'b001);
    c = cmd_count;
    HRESET = 1'b0;
    load_gen++;
    run_load(1'b0, "midrst", 1'b0);
    chk("midrst_cmd_resent", cmd_count - c, 1);
    chk("midrst_word0", got_word[0], 128'h201F1E1D1C1B1A191817161514131211);

`ifdef PRELOAD_CHECKSUM_EN
    // trailer off by one must flag an error and keep the CPU held
    restart(8'h22, 1);
    run_load(1'b0, "badsum", 1'b1);
    chk("badsum_done", PRELOAD_DONE, 1'b1);
    restart(8'h33, 0);
    run_load(1'b0, "goodsum", 1'b0);
`endif

    repeat (5) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
